// File: rtl/imem_loader_ctrl_pkg.sv
// Shared constants and loader state encoding for the instruction-memory loader.
// The optional trailer checksum is enabled by defining IMEM_LOADER_CHECKSUM_EN (off by default).
package imem_loader_ctrl_pkg;

  localparam int IMEM_ADDR_W = 10;
  localparam int IMEM_DEPTH  = 1 << IMEM_ADDR_W;
  localparam int WORD_W      = 32;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_LOAD  = 2'd1,
    ST_CHECK = 2'd2,
    ST_ERR   = 2'd3
  } ld_state_t;

endpackage

// File: rtl/imem_loader_ctrl_byte_word_packer.sv
// Packs accepted bytes little-endian into 32-bit words; word_valid pulses the
// cycle after the 4th byte, while word still holds the completed value.
module byte_word_packer
  import imem_loader_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic [7:0]        byte_in,
  input  logic              byte_vld,
  output logic [WORD_W-1:0] word,
  output logic              word_valid,
  output logic              last
);

  logic [1:0] bcnt;

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      bcnt       <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= byte_vld && (bcnt == 2'd3);
      if (byte_vld) begin
        word[{bcnt, 3'b000} +: 8] <= byte_in;
        bcnt                      <= bcnt + 2'd1;
      end
    end
  end

  assign last = (bcnt == 2'd3);

endmodule

// File: rtl/imem_loader_ctrl.sv
// Owns the instruction-memory port: downloads a byte stream into words 0..len-1
// while holding the core in reset. Trailer checksum enabled by IMEM_LOADER_CHECKSUM_EN.
module imem_loader_ctrl
  import imem_loader_ctrl_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic [ADDR_W:0]   load_len,
  input  logic [7:0]        s_byte,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [ADDR_W-1:0] im_addr,
  output logic              im_we,
  output logic [WORD_W-1:0] im_wdata,
  output logic              cpu_rst_n,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  function automatic logic [ADDR_W:0] sat_len(input logic [ADDR_W:0] l);
    return (l > DEPTH) ? DEPTH : l;
  endfunction

  ld_state_t         state;
  logic [ADDR_W:0]   word_cnt;
  logic [ADDR_W:0]   last_idx;
  logic              hs;
  logic              start_go;
  logic              final_word;
  logic              pk_vld;
  logic              pk_last;

  assign hs         = s_valid && s_ready;
  assign start_go   = load_start && (load_len != '0) && (state == ST_RUN || state == ST_ERR);
  assign final_word = (word_cnt == last_idx);
  assign im_addr    = (state == ST_LOAD) ? word_cnt[ADDR_W-1:0] : fetch_addr;

  byte_word_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (start_go),
    .byte_in    (s_byte),
    .byte_vld   (hs),
    .word       (im_wdata),
    .word_valid (pk_vld),
    .last       (pk_last)
  );

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [WORD_W-1:0] sum;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_RUN;
      word_cnt  <= '0;
      last_idx  <= '0;
      s_ready   <= 1'b0;
      im_we     <= 1'b0;
      cpu_rst_n <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      err       <= 1'b0;
      sum       <= '0;
`endif
    end else begin
      im_we <= 1'b0;
      done  <= 1'b0;
      case (state)
        ST_RUN: begin
          cpu_rst_n <= 1'b1;
          if (load_start && load_len == '0) done <= 1'b1;
        end
        ST_LOAD: begin
          if (hs && pk_last) begin
            im_we <= 1'b1;
`ifndef IMEM_LOADER_CHECKSUM_EN
            if (final_word) s_ready <= 1'b0;
`endif
          end
          if (pk_vld) begin
            word_cnt <= word_cnt + 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum <= sum + im_wdata;
            if (final_word) state <= ST_CHECK;
`else
            if (final_word) begin
              state <= ST_RUN;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
`endif
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        // Trailer word arrives through the same packer; ready stays up until it is complete
        ST_CHECK: begin
          if (hs && pk_last) s_ready <= 1'b0;
          if (pk_vld) begin
            if (im_wdata == sum) begin
              state <= ST_RUN;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= ST_ERR;
              err   <= 1'b1;
            end
          end
        end
        ST_ERR: ;
`endif
        default: state <= ST_RUN;
      endcase

      // Starting a load overrides whatever the state branch above scheduled
      if (start_go) begin
        state     <= ST_LOAD;
        word_cnt  <= '0;
        last_idx  <= sat_len(load_len) - 1'b1;
        s_ready   <= 1'b1;
        cpu_rst_n <= 1'b0;
        busy      <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        err       <= 1'b0;
        sum       <= '0;
`endif
      end
    end
  end

`ifndef IMEM_LOADER_CHECKSUM_EN
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader_ctrl.sv
// Self-checking bench for imem_loader_ctrl: vector table, hand sequences and
// randomized downloads compared against a word-level model of the download.
module tb_imem_loader_ctrl;

  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          load_start;
  logic [AW:0]   load_len;
  logic [7:0]    s_byte;
  logic          s_valid;
  logic          s_ready;
  logic [AW-1:0] fetch_addr;
  logic [AW-1:0] im_addr;
  logic          im_we;
  logic [31:0]   im_wdata;
  logic          cpu_rst_n;
  logic          busy;
  logic          done;
  logic          err;

  imem_loader_ctrl #(.ADDR_W(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_start (load_start),
    .load_len   (load_len),
    .s_byte     (s_byte),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .fetch_addr (fetch_addr),
    .im_addr    (im_addr),
    .im_we      (im_we),
    .im_wdata   (im_wdata),
    .cpu_rst_n  (cpu_rst_n),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Observed activity, sampled just after each rising edge
  int          cyc = 0;
  int          done_cnt, done_cyc, rise_cyc, last_we_cyc, start_cyc;
  bit          done_busy, cpu_low_seen;
  logic        prev_cpu = 1'b1;
  int          wr_addr_q[$];
  logic [31:0] wr_data_q[$];

  always @(posedge clk) begin
    #1;
    cyc++;
    if (im_we) begin
      wr_addr_q.push_back(int'(im_addr));
      wr_data_q.push_back(im_wdata);
      last_we_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc  = cyc;
      done_busy = busy;
    end
    if (!cpu_rst_n) cpu_low_seen = 1'b1;
    if (cpu_rst_n && !prev_cpu) rise_cyc = cyc;
    prev_cpu = cpu_rst_n;
  end

  logic [7:0] sbytes [0:4199];

  typedef struct {
    int          len;
    logic [63:0] bytes;
    int          gap;
    int          exp_nwr;
    logic [31:0] exp_w0;
    logic [31:0] exp_w1;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_word(input int i);
    return 32'(sbytes[4*i]) + (32'(sbytes[4*i+1]) << 8) +
           (32'(sbytes[4*i+2]) << 16) + (32'(sbytes[4*i+3]) << 24);
  endfunction

  function automatic int words_for(input int len);
    return (len > DEPTH) ? DEPTH : len;
  endfunction

  task automatic prepare(input int len, input logic [63:0] head);
    logic [31:0] s;
    int n;
    for (int i = 0; i < 4200; i++) sbytes[i] = 8'($urandom);
    for (int i = 0; i < 8; i++) sbytes[i] = head[8*i +: 8];
    n = words_for(len);
    s = '0;
    for (int i = 0; i < n; i++) s += model_word(i);
    if (CK) for (int i = 0; i < 4; i++) sbytes[4*n+i] = s[8*i +: 8];
  endtask

  task automatic clear_mon();
    wr_addr_q.delete();
    wr_data_q.delete();
    done_cnt     = 0;
    done_cyc     = -1;
    rise_cyc     = -1;
    last_we_cyc  = -1;
    cpu_low_seen = 1'b0;
  endtask

  // Offers bytes until the controller drops ready after accepting at least one
  task automatic stream(input int total, input int gap, output int acc);
    int   n_cyc;
    bit   v;
    logic rdy;
    acc   = 0;
    n_cyc = 0;
    while (1) begin
      if (acc > 0 && !s_ready) break;
      if (n_cyc >= 20 * total + 100) begin
        checks++;
        errors++;
        $display("FAIL stream_budget actual=%0d required_accepted_before_ready_drop", acc);
        break;
      end
      v = (acc < total) && (gap == 0 || (gap == 1 && n_cyc % 2 == 1) ||
                            (gap == 2 && $urandom_range(0, 1) == 1));
      s_valid = v;
      s_byte  = (acc < total) ? sbytes[acc] : 8'h00;
      rdy     = s_ready;
      @(negedge clk);
      n_cyc++;
      if (v && rdy) acc++;
    end
    s_valid = 1'b0;
  endtask

  task automatic do_load(input int len, input int gap, output int acc);
    int n;
    n = words_for(len);
    clear_mon();
    fetch_addr = AW'($urandom_range(1, DEPTH - 1));
    load_len   = (AW+1)'(len);
    load_start = 1'b1;
    start_cyc  = cyc;
    @(negedge clk);
    load_start = 1'b0;
    acc = 0;
    if (len != 0) begin
      chk("start_busy", busy, 1);
      chk("start_cpu_rst_n", cpu_rst_n, 0);
      chk("start_s_ready", s_ready, 1);
      chk("load_im_addr", im_addr, 0);
      stream(4 * n + (CK ? 4 : 0) + 8, gap, acc);
    end
    for (int i = 0; i < 30 && done_cnt == 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_load(input int len, input int acc);
    int n;
    n = words_for(len);
    chk("accepted_bytes", acc, (n == 0) ? 0 : 4 * n + (CK ? 4 : 0));
    chk("write_count", wr_addr_q.size(), n);
    for (int i = 0; i < n && i < wr_addr_q.size(); i++) begin
      chk("write_addr", wr_addr_q[i], i);
      chk("write_data", wr_data_q[i], model_word(i));
    end
    chk("done_count", done_cnt, 1);
    chk("done_busy", done_busy, 0);
    if (n == 0) begin
      chk("done_latency", done_cyc, start_cyc + 1);
      chk("cpu_rst_held_high", cpu_low_seen, 0);
    end else begin
      chk("cpu_release", rise_cyc, done_cyc + 1);
      if (!CK) chk("done_after_write", done_cyc, last_we_cyc + 1);
    end
    chk("end_cpu_rst_n", cpu_rst_n, 1);
    chk("end_busy", busy, 0);
    chk("end_s_ready", s_ready, 0);
    fetch_addr = AW'($urandom);
    #1;
    chk("run_fetch_passthru", im_addr, fetch_addr);
  endtask

  initial begin
    int acc;
    int len;
    rst_n      = 1'b0;
    load_start = 1'b0;
    load_len   = '0;
    s_byte     = '0;
    s_valid    = 1'b0;
    fetch_addr = AW'(5);

    vecs[0] = '{2, 64'hDEADBEEF_12345678, 0, 2, 32'h12345678, 32'hDEADBEEF};
    vecs[1] = '{2, 64'hDEADBEEF_12345678, 1, 2, 32'h12345678, 32'hDEADBEEF};
    vecs[2] = '{2, 64'hDEADBEEF_12345678, 2, 2, 32'h12345678, 32'hDEADBEEF};
    vecs[3] = '{1, 64'h00000000_04030201, 0, 1, 32'h04030201, 32'h0};
    vecs[4] = '{0, 64'h00000000_00000000, 0, 0, 32'h0, 32'h0};

    repeat (3) @(negedge clk);
    chk("rst_cpu_rst_n", cpu_rst_n, 1);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_im_we", im_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_cpu_rst_n", cpu_rst_n, 1);
    chk("idle_s_ready", s_ready, 0);
    chk("idle_busy", busy, 0);
    chk("idle_im_we", im_we, 0);
    chk("idle_im_addr", im_addr, 10'h005);

    // Vector table
    for (int v = 0; v < 5; v++) begin
      prepare(vecs[v].len, vecs[v].bytes);
      do_load(vecs[v].len, vecs[v].gap, acc);
      chk("vec_write_count", wr_addr_q.size(), vecs[v].exp_nwr);
      if (vecs[v].exp_nwr >= 1 && wr_addr_q.size() >= 1) begin
        chk("vec_addr0", wr_addr_q[0], 0);
        chk("vec_word0", wr_data_q[0], vecs[v].exp_w0);
      end
      if (vecs[v].exp_nwr >= 2 && wr_addr_q.size() >= 2) begin
        chk("vec_addr1", wr_addr_q[1], 1);
        chk("vec_word1", wr_data_q[1], vecs[v].exp_w1);
      end
      check_load(vecs[v].len, acc);
    end

    // Reset after 5 bytes of a 2-word load
    prepare(2, 64'hDEADBEEF_12345678);
    clear_mon();
    load_len   = 11'd2;
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1;
      s_byte  = sbytes[i];
      @(negedge clk);
    end
    s_valid = 1'b0;
    rst_n   = 1'b0;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_s_ready", s_ready, 0);
    chk("midrst_cpu_rst_n", cpu_rst_n, 1);
    chk("midrst_im_addr", im_addr, fetch_addr);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_write_count", wr_addr_q.size(), 1);
    if (wr_addr_q.size() >= 1) begin
      chk("midrst_addr0", wr_addr_q[0], 0);
      chk("midrst_word0", wr_data_q[0], 32'h12345678);
    end
    chk("midrst_no_done", done_cnt, 0);
    // A fresh load after the interrupted one must not see the discarded partial word
    prepare(1, 64'h0000_0000_A1B2C3D4);
    do_load(1, 0, acc);
    check_load(1, acc);

    // Oversized length saturates to the full memory depth
    prepare(2047, {$urandom, $urandom});
    do_load(2047, 0, acc);
    check_load(2047, acc);

    // Randomized downloads against the model
    for (int r = 0; r < 12; r++) begin
      len = $urandom_range(1, 8);
      prepare(len, {$urandom, $urandom});
      do_load(len, $urandom_range(0, 2), acc);
      check_load(len, acc);
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Wrong trailer: controller must park in ERR until the next load_start
    prepare(2, 64'hDEADBEEF_12345678);
    for (int i = 8; i < 12; i++) sbytes[i] = 8'h00;
    do_load(2, 0, acc);
    chk("ck_bad_err", err, 1);
    chk("ck_bad_cpu_rst_n", cpu_rst_n, 0);
    chk("ck_bad_busy", busy, 1);
    chk("ck_bad_done", done_cnt, 0);
    prepare(1, 64'h0000_0000_0BADF00D);
    do_load(1, 0, acc);
    chk("ck_retry_err", err, 0);
    check_load(1, acc);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
